// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   - State encoding of the access FSM (IDLE / ACCESS / DONE).
//   - Requester identifiers used for the grant and round-robin history.
//   - rr_pick(): two-way round-robin selection helper.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_DONE   = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = STATE_IDLE,
        StAccess = STATE_ACCESS,
        StDone   = STATE_DONE
    } state_e;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

    // On a tie the requester that was not granted last wins; otherwise the
    // single active requester wins. Only meaningful when a request is present.
    function automatic logic rr_pick(input logic cpu_req, input logic dbg_req,
                                     input logic last_grant);
        logic pick;
        if (cpu_req && dbg_req) begin
            pick = (last_grant == GRANT_DBG) ? GRANT_CPU : GRANT_DBG;
        end else if (cpu_req) begin
            pick = GRANT_CPU;
        end else begin
            pick = GRANT_DBG;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_wait_counter.sv
// Wait-state counter for the access FSM.
//   clk_i         : clock, rising edge.
//   rst_i         : synchronous active-high reset (count -> 0).
//   clear_i       : load zero (asserted on grant).
//   inc_i         : increment by one.
//   terminal_o    : count == WAIT_STATES (final ACCESS cycle).
//   penultimate_o : count == WAIT_STATES-1 (next cycle is the final one);
//                   never set when WAIT_STATES == 0.
module mem_bus_arbiter_wait_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES    = 2,
    parameter int unsigned DATAWIDTH_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic terminal_o,
    output logic penultimate_o
);

    localparam logic [DATAWIDTH_WAIT-1:0] COUNT_TERM   = DATAWIDTH_WAIT'(WAIT_STATES);
    localparam logic [DATAWIDTH_WAIT-1:0] COUNT_PENULT =
        DATAWIDTH_WAIT'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic HAS_WAIT = (WAIT_STATES != 0);

    logic [DATAWIDTH_WAIT-1:0] count_q;
    logic [DATAWIDTH_WAIT-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + DATAWIDTH_WAIT'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o    = (count_q == COUNT_TERM);
    assign penultimate_o = HAS_WAIT && (count_q == COUNT_PENULT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one single-port memory between the CPU datapath
// and a debug/program-loader port.
//   Clock/reset : MEM_BUS_ARBITER_CLOCK_50, MEM_BUS_ARBITER_ResetInHigh_In (sync, active high).
//   CPU port    : RD/WR level requests, address, write data; registered read data and
//                 a one-cycle ACK. RD and WR together mean a write.
//   DBG port    : level request with direction bit, address, write data; registered
//                 read data and a one-cycle ACK.
//   MEM port    : latched address/write data, RE for every access cycle of a read,
//                 WE in the final access cycle of a write, read data input.
// A grant latches the requester's command, then the FSM spends WAIT_STATES+1 cycles
// in ACCESS, one cycle in DONE (ACK) and always returns to IDLE for one cycle, so a
// held request cannot be re-granted before its ACK is seen. All strobes and ACKs are
// registered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH_ADDRESS = 32,
    parameter int unsigned DATAWIDTH_DATA    = 32,
    parameter int unsigned WAIT_STATES       = 2,
    parameter int unsigned DATAWIDTH_WAIT    = 4
) (
    input  logic                         MEM_BUS_ARBITER_CLOCK_50,
    input  logic                         MEM_BUS_ARBITER_ResetInHigh_In,
    input  logic                         MEM_BUS_ARBITER_CPU_RD_In,
    input  logic                         MEM_BUS_ARBITER_CPU_WR_In,
    input  logic [DATAWIDTH_ADDRESS-1:0] MEM_BUS_ARBITER_CPU_Address_InBus,
    input  logic [DATAWIDTH_DATA-1:0]    MEM_BUS_ARBITER_CPU_WriteData_InBus,
    output logic [DATAWIDTH_DATA-1:0]    MEM_BUS_ARBITER_CPU_ReadData_OutBus,
    output logic                         MEM_BUS_ARBITER_CPU_ACK_Out,
    input  logic                         MEM_BUS_ARBITER_DBG_Req_In,
    input  logic                         MEM_BUS_ARBITER_DBG_WR_In,
    input  logic [DATAWIDTH_ADDRESS-1:0] MEM_BUS_ARBITER_DBG_Address_InBus,
    input  logic [DATAWIDTH_DATA-1:0]    MEM_BUS_ARBITER_DBG_WriteData_InBus,
    output logic [DATAWIDTH_DATA-1:0]    MEM_BUS_ARBITER_DBG_ReadData_OutBus,
    output logic                         MEM_BUS_ARBITER_DBG_ACK_Out,
    output logic [DATAWIDTH_ADDRESS-1:0] MEM_BUS_ARBITER_MEM_Address_OutBus,
    output logic [DATAWIDTH_DATA-1:0]    MEM_BUS_ARBITER_MEM_WriteData_OutBus,
    output logic                         MEM_BUS_ARBITER_MEM_RE_Out,
    output logic                         MEM_BUS_ARBITER_MEM_WE_Out,
    input  logic [DATAWIDTH_DATA-1:0]    MEM_BUS_ARBITER_MEM_ReadData_InBus
);

    localparam logic ZERO_WAIT = (WAIT_STATES == 0);

    logic clk;
    logic rst;
    assign clk = MEM_BUS_ARBITER_CLOCK_50;
    assign rst = MEM_BUS_ARBITER_ResetInHigh_In;

    state_e                       state_q,      state_d;
    logic                         grant_q,      grant_d;
    logic                         last_grant_q, last_grant_d;
    logic                         write_q,      write_d;
    logic [DATAWIDTH_ADDRESS-1:0] mem_addr_q,   mem_addr_d;
    logic [DATAWIDTH_DATA-1:0]    mem_wdata_q,  mem_wdata_d;
    logic                         mem_re_q,     mem_re_d;
    logic                         mem_we_q,     mem_we_d;
    logic                         cpu_ack_q,    cpu_ack_d;
    logic                         dbg_ack_q,    dbg_ack_d;
    logic [DATAWIDTH_DATA-1:0]    cpu_rdata_q,  cpu_rdata_d;
    logic [DATAWIDTH_DATA-1:0]    dbg_rdata_q,  dbg_rdata_d;

    logic cpu_req;
    logic dbg_req;
    logic grant_sel;
    logic cnt_clear;
    logic cnt_inc;
    logic cnt_terminal;
    logic cnt_penultimate;

    assign cpu_req   = MEM_BUS_ARBITER_CPU_RD_In | MEM_BUS_ARBITER_CPU_WR_In;
    assign dbg_req   = MEM_BUS_ARBITER_DBG_Req_In;
    assign grant_sel = rr_pick(cpu_req, dbg_req, last_grant_q);

    mem_bus_arbiter_wait_counter #(
        .WAIT_STATES    (WAIT_STATES),
        .DATAWIDTH_WAIT (DATAWIDTH_WAIT)
    ) u_wait_counter (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (cnt_clear),
        .inc_i         (cnt_inc),
        .terminal_o    (cnt_terminal),
        .penultimate_o (cnt_penultimate)
    );

    // Strobes and ACKs are computed for the *next* cycle so they leave the
    // block straight from flops.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req || dbg_req) begin
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    if (grant_sel == GRANT_CPU) begin
                        write_d     = MEM_BUS_ARBITER_CPU_WR_In;
                        mem_addr_d  = MEM_BUS_ARBITER_CPU_Address_InBus;
                        mem_wdata_d = MEM_BUS_ARBITER_CPU_WriteData_InBus;
                    end else begin
                        write_d     = MEM_BUS_ARBITER_DBG_WR_In;
                        mem_addr_d  = MEM_BUS_ARBITER_DBG_Address_InBus;
                        mem_wdata_d = MEM_BUS_ARBITER_DBG_WriteData_InBus;
                    end
                    cnt_clear = 1'b1;
                    state_d   = StAccess;
                    mem_re_d  = ~write_d;
                    // With no wait states the first ACCESS cycle is also the last.
                    mem_we_d  = write_d & ZERO_WAIT;
                end
            end

            StAccess: begin
                if (cnt_terminal) begin
                    if (!write_q) begin
                        if (grant_q == GRANT_CPU) begin
                            cpu_rdata_d = MEM_BUS_ARBITER_MEM_ReadData_InBus;
                        end else begin
                            dbg_rdata_d = MEM_BUS_ARBITER_MEM_ReadData_InBus;
                        end
                    end
                    cpu_ack_d = (grant_q == GRANT_CPU);
                    dbg_ack_d = (grant_q == GRANT_DBG);
                    state_d   = StDone;
                end else begin
                    cnt_inc  = 1'b1;
                    mem_re_d = ~write_q;
                    mem_we_d = write_q & cnt_penultimate;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= GRANT_CPU;
            last_grant_q <= GRANT_DBG;
            write_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign MEM_BUS_ARBITER_CPU_ReadData_OutBus  = cpu_rdata_q;
    assign MEM_BUS_ARBITER_CPU_ACK_Out          = cpu_ack_q;
    assign MEM_BUS_ARBITER_DBG_ReadData_OutBus  = dbg_rdata_q;
    assign MEM_BUS_ARBITER_DBG_ACK_Out          = dbg_ack_q;
    assign MEM_BUS_ARBITER_MEM_Address_OutBus   = mem_addr_q;
    assign MEM_BUS_ARBITER_MEM_WriteData_OutBus = mem_wdata_q;
    assign MEM_BUS_ARBITER_MEM_RE_Out           = mem_re_q;
    assign MEM_BUS_ARBITER_MEM_WE_Out           = mem_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a transaction-timeline model predicts every output per
// cycle; directed scenarios add literal cycle-exact expectations.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned W  = 2;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          dbg_req = 1'b0, dbg_wr = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re, mem_we;
    logic [DW-1:0] mem_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .DATAWIDTH_ADDRESS (AW),
        .DATAWIDTH_DATA    (DW),
        .WAIT_STATES       (W),
        .DATAWIDTH_WAIT    (CW)
    ) dut (
        .MEM_BUS_ARBITER_CLOCK_50             (clk),
        .MEM_BUS_ARBITER_ResetInHigh_In       (rst),
        .MEM_BUS_ARBITER_CPU_RD_In            (cpu_rd),
        .MEM_BUS_ARBITER_CPU_WR_In            (cpu_wr),
        .MEM_BUS_ARBITER_CPU_Address_InBus    (cpu_addr),
        .MEM_BUS_ARBITER_CPU_WriteData_InBus  (cpu_wdata),
        .MEM_BUS_ARBITER_CPU_ReadData_OutBus  (cpu_rdata),
        .MEM_BUS_ARBITER_CPU_ACK_Out          (cpu_ack),
        .MEM_BUS_ARBITER_DBG_Req_In           (dbg_req),
        .MEM_BUS_ARBITER_DBG_WR_In            (dbg_wr),
        .MEM_BUS_ARBITER_DBG_Address_InBus    (dbg_addr),
        .MEM_BUS_ARBITER_DBG_WriteData_InBus  (dbg_wdata),
        .MEM_BUS_ARBITER_DBG_ReadData_OutBus  (dbg_rdata),
        .MEM_BUS_ARBITER_DBG_ACK_Out          (dbg_ack),
        .MEM_BUS_ARBITER_MEM_Address_OutBus   (mem_addr),
        .MEM_BUS_ARBITER_MEM_WriteData_OutBus (mem_wdata),
        .MEM_BUS_ARBITER_MEM_RE_Out           (mem_re),
        .MEM_BUS_ARBITER_MEM_WE_Out           (mem_we),
        .MEM_BUS_ARBITER_MEM_ReadData_InBus   (mem_rdata)
    );

    // Simple memory: 256 words, default content 0xA5A5_00aa, word 0x10 = 0xDEADBEEF.
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[8'h10] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline per transaction: grant sampled at the end of cycle 0; cycles
    // 1..W+1 access, cycle W+2 ACK, cycle W+3 forced idle.
    bit            model_valid = 0;
    bit            busy = 0;
    int            k = 0;
    logic          m_gnt = 1'b0;        // 0 = CPU, 1 = DBG
    logic          m_last = 1'b1;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          e_re = 0, e_we = 0, e_cack = 0, e_dack = 0;
    logic [DW-1:0] e_crd = '0, e_drd = '0;

    always @(posedge clk) begin
        logic creq;
        creq        = cpu_rd | cpu_wr;
        model_valid = 1;
        e_re = 0; e_we = 0; e_cack = 0; e_dack = 0;
        if (rst) begin
            busy = 0; m_last = 1'b1; e_crd = '0; e_drd = '0; m_addr = '0; m_wdata = '0;
        end else if (busy) begin
            k++;
            if (k == int'(W) + 3) begin
                busy = 0;
            end else if (k <= int'(W) + 1) begin
                e_re = !m_wr;
                e_we = m_wr && (k == int'(W) + 1);
            end else begin
                if (m_gnt) e_dack = 1; else e_cack = 1;
                if (!m_wr) begin
                    if (m_gnt) e_drd = mem[m_addr[7:0]];
                    else       e_crd = mem[m_addr[7:0]];
                end
            end
        end else if (creq || dbg_req) begin
            m_gnt   = creq ? (dbg_req ? !m_last : 1'b0) : 1'b1;
            m_last  = m_gnt;
            m_wr    = m_gnt ? dbg_wr : cpu_wr;
            m_addr  = m_gnt ? dbg_addr : cpu_addr;
            m_wdata = m_gnt ? dbg_wdata : cpu_wdata;
            busy    = 1;
            k       = 1;
            e_re    = !m_wr;
            e_we    = m_wr && (W == 0);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
            chk("dbg_ack", 32'(dbg_ack), 32'(e_dack));
            chk("mem_re", 32'(mem_re), 32'(e_re));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("dbg_rdata", dbg_rdata, e_drd);
            if (e_re || e_we) chk("mem_addr", mem_addr, m_addr);
            if (e_we)         chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int ack_cyc[$];
    int ack_port[$];

    initial begin
        tick(2);
        rst = 1'b0;
        tick();
        chk("reset_cpu_rdata", cpu_rdata, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_acks", 32'({cpu_ack, dbg_ack, mem_re, mem_we}), 32'h0);

        // CPU read of 0x10
        cpu_rd = 1'b1; cpu_addr = 32'h10;
        tick(); chk("t1_re_c1", 32'(mem_re), 32'h1);
        tick(2); chk("t1_re_c3", 32'(mem_re), 32'h1);
        chk("t1_addr_c3", mem_addr, 32'h10);
        tick(); chk("t1_ack_c4", 32'(cpu_ack), 32'h1);
        chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t1_dbg_ack", 32'(dbg_ack), 32'h0);
        chk("t1_re_c4", 32'(mem_re), 32'h0);
        cpu_rd = 1'b0;
        tick(); chk("t1_ack_c5", 32'(cpu_ack), 32'h0);

        // DBG write 0x12345678 to 0x20
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
        tick(); chk("t2_we_c1", 32'(mem_we), 32'h0);
        tick(); chk("t2_we_c2", 32'(mem_we), 32'h0);
        tick(); chk("t2_we_c3", 32'(mem_we), 32'h1);
        chk("t2_addr", mem_addr, 32'h20);
        chk("t2_wdata", mem_wdata, 32'h1234_5678);
        tick(); chk("t2_ack_c4", 32'(dbg_ack), 32'h1);
        chk("t2_cpu_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        chk("t2_dbg_rdata_kept", dbg_rdata, 32'h0);
        dbg_req = 1'b0; dbg_wr = 1'b0;
        tick();

        // Simultaneous held requests after reset: CPU, DBG, CPU, DBG
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 32'h40;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (cpu_ack) begin ack_cyc.push_back(c); ack_port.push_back(0); end
            if (dbg_ack) begin ack_cyc.push_back(c); ack_port.push_back(1); end
        end
        cpu_rd = 1'b0; dbg_req = 1'b0;
        chk("t3_ack_count", 32'(ack_cyc.size()), 32'd4);
        for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
            chk("t3_ack_cycle", 32'(ack_cyc[i]), 32'(4 + 5 * i));
            chk("t3_ack_port", 32'(ack_port[i]), 32'(i % 2));
        end
        chk("t3_dbg_rdata", dbg_rdata, 32'hA5A5_0040);
        tick(2);

        // RD and WR together: write
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFE_F00D;
        tick(); chk("t4_re_c1", 32'(mem_re), 32'h0);
        tick(2); chk("t4_we_c3", 32'(mem_we), 32'h1);
        chk("t4_re_c3", 32'(mem_re), 32'h0);
        tick(); chk("t4_ack_c4", 32'(cpu_ack), 32'h1);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick();

        // Address change during ACCESS
        cpu_rd = 1'b1; cpu_addr = 32'h10;
        tick(); cpu_addr = 32'h99;
        tick(); chk("t5_addr_held", mem_addr, 32'h10);
        tick(2); chk("t5_ack_c4", 32'(cpu_ack), 32'h1);
        chk("t5_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_rd = 1'b0;
        tick();

        // Request withdrawn in cycle 2; reads back the earlier write
        cpu_rd = 1'b1; cpu_addr = 32'h30;
        tick(2); cpu_rd = 1'b0;
        tick(2); chk("t5b_ack_c4", 32'(cpu_ack), 32'h1);
        chk("t5b_rdata", cpu_rdata, 32'hCAFE_F00D);
        tick();

        // Reset in cycle 2 of a DBG write to 0x50
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 32'h50; dbg_wdata = 32'h55;
        tick(2); rst = 1'b1;
        tick();
        chk("t6_we", 32'(mem_we), 32'h0);
        chk("t6_ack", 32'({cpu_ack, dbg_ack}), 32'h0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        chk("t6_cpu_rdata", cpu_rdata, 32'h0);
        rst = 1'b0; dbg_req = 1'b0; dbg_wr = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 32'h50;
        tick(4); chk("t6_fresh_ack", 32'(cpu_ack), 32'h1);
        chk("t6_no_write", cpu_rdata, 32'hA5A5_0050);
        cpu_rd = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port main memory between the microsequenced CPU datapath (RD/WR strobes, waits on ACK) and a debug/program-loader port.
- Two-way round-robin arbitration.
- Fixed wait-state access FSM that latches address and data at grant.
- Returns a one-cycle ACK and registered read data to the granted requester.
- Sits between the control unit/datapath and the memory macro; its CPU ACK drives the microcode address incrementer's ACK input.

Parameters:
- DATAWIDTH_ADDRESS, 32, memory address width.
- DATAWIDTH_DATA, 32, memory word width.
- WAIT_STATES, 2, extra memory cycles per access (0..15 legal).
- DATAWIDTH_WAIT, 4, wait counter width; must hold WAIT_STATES.

Ports:
- MEM_BUS_ARBITER_CLOCK_50  in  1  system clock; all state changes on rising edge.
- MEM_BUS_ARBITER_ResetInHigh_In  in  1  synchronous, active-high reset.
- MEM_BUS_ARBITER_CPU_RD_In  in  1  CPU read request (level, held until ACK).
- MEM_BUS_ARBITER_CPU_WR_In  in  1  CPU write request (level, held until ACK).
- MEM_BUS_ARBITER_CPU_Address_InBus  in  DATAWIDTH_ADDRESS  CPU address.
- MEM_BUS_ARBITER_CPU_WriteData_InBus  in  DATAWIDTH_DATA  CPU write data.
- MEM_BUS_ARBITER_CPU_ReadData_OutBus  out  DATAWIDTH_DATA  CPU read data, registered.
- MEM_BUS_ARBITER_CPU_ACK_Out  out  1  CPU completion pulse.
- MEM_BUS_ARBITER_DBG_Req_In  in  1  debug request (level, held until ACK).
- MEM_BUS_ARBITER_DBG_WR_In  in  1  debug direction: 1 = write, 0 = read.
- MEM_BUS_ARBITER_DBG_Address_InBus  in  DATAWIDTH_ADDRESS  debug address.
- MEM_BUS_ARBITER_DBG_WriteData_InBus  in  DATAWIDTH_DATA  debug write data.
- MEM_BUS_ARBITER_DBG_ReadData_OutBus  out  DATAWIDTH_DATA  debug read data, registered.
- MEM_BUS_ARBITER_DBG_ACK_Out  out  1  debug completion pulse.
- MEM_BUS_ARBITER_MEM_Address_OutBus  out  DATAWIDTH_ADDRESS  latched memory address.
- MEM_BUS_ARBITER_MEM_WriteData_OutBus  out  DATAWIDTH_DATA  latched write data.
- MEM_BUS_ARBITER_MEM_RE_Out  out  1  memory read enable.
- MEM_BUS_ARBITER_MEM_WE_Out  out  1  memory write strobe.
- MEM_BUS_ARBITER_MEM_ReadData_InBus  in  DATAWIDTH_DATA  memory read data.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, wait counter = 0, last_grant = DBG, so the CPU wins the first tie.
  - All outputs 0, including both ReadData buses and the MEM buses.
- CPU request = CPU_RD | CPU_WR. If both are asserted, the access is a write.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is present, grant it and go to ACCESS.
  - If only one requester is active, it is granted.
  - If both are active, grant the requester that is not last_grant, then update last_grant.
  - On grant, latch grant ID, direction, address and write data; counter = 0.
- ACCESS:
  - Lasts WAIT_STATES+1 cycles. MEM_Address and MEM_WriteData hold the latched values.
  - Read: MEM_RE = 1 for every ACCESS cycle.
  - Write: MEM_WE = 1 only in the final ACCESS cycle (counter == WAIT_STATES).
  - Counter increments each cycle.
  - On the final cycle: for a read, capture MEM_ReadData into the granted port's ReadData register; then go to DONE.
- DONE:
  - Granted port's ACK = 1 for exactly this one cycle; the other ACK stays 0.
  - Always return to IDLE. This forces one idle cycle between transactions, so a held request is not re-granted before the requester sees its ACK.
- Latency, with cycle 0 = IDLE cycle that samples the request:
  - Cycles 1..WAIT_STATES+1 are ACCESS.
  - ACK is in cycle WAIT_STATES+2 (default: cycle 4).
  - The earliest next grant is sampled in cycle WAIT_STATES+3.
- ReadData registers hold their value until the next read completes for that same port. Writes never modify them.
- Input changes after grant (address, data, request withdrawn) do not affect the access in flight. The access completes and ACK is still pulsed.
- Reset mid-ACCESS: the next cycle is IDLE; MEM_WE and MEM_RE are 0 and no ACK is issued.
- WAIT_STATES = 0: ACCESS is a single cycle and MEM_WE pulses in it.
- ACK_Out, MEM_RE and MEM_WE are registered-state decodes: glitch-free and never asserted in IDLE.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - requester IDs (GRANT_CPU = 1'b0, GRANT_DBG = 1'b1).
- One natural sub-module: mem_bus_arbiter_wait_counter.
  - Load-to-zero on grant, increment, and a terminal flag when count == WAIT_STATES.
  - Reused by the FSM for the final-cycle decode.

Test Plan:
- Basic access:
  - CPU read A = 0x10; memory returns 0xDEADBEEF; WAIT_STATES = 2.
  - RE is high in cycles 1-3; CPU_ACK pulses in cycle 4; CPU_ReadData = 0xDEADBEEF; DBG_ACK stays 0.
- DBG write:
  - A = 0x20, D = 0x12345678.
  - MEM_WE is high only in cycle 3 with MEM_Address = 0x20 and MEM_WriteData = 0x12345678; DBG_ACK in cycle 4; both ReadData buses unchanged.
- Simultaneous requests after reset:
  - Both held continuously.
  - Grants are CPU, DBG, CPU, DBG; the ACKs alternate, spaced 5 cycles apart.
- Write priority: CPU_RD = CPU_WR = 1 at A = 0x30 → a write is performed (WE pulse, no RE).
- Mid-access input change and withdrawal:
  - Change CPU_Address to 0x99 during ACCESS → MEM_Address stays 0x10 and ACK still fires.
  - Deassert the request in cycle 2 → ACK still fires in cycle 4.
- Reset in cycle 2 of a write: no WE pulse and no ACK; all outputs 0 next cycle; a fresh request is granted normally.
